// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - ps2_state_t : host transmitter FSM states
//   - ERR_*       : err_code values reported with the error pulse
//   - CMD_*       : common host-to-keyboard command bytes
//   - KEY_*       : set-2 make codes for W/A/S/D, shared with the receiver
//   - odd_parity(): parity bit that makes the 9-bit {parity, byte} odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings one raw PS/2 line into the clk domain and flags
// falling edges of the synchronized level.
//   clk       in  system clock
//   reset     in  asynchronous, active-high
//   line_in   in  raw line level (asynchronous)
//   line_sync out synchronized line level
//   fall      out high for one cycle when line_sync goes 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset to 1 (idle bus level) so leaving reset never fakes a fall.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign line_sync = sync;
    assign fall      = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to
// the keyboard using open-drain enables on the shared clock/data lines.
//   clk          in  system clock
//   reset        in  asynchronous, active-high
//   start        in  one-cycle request, accepted only in IDLE
//   cmd[7:0]     in  byte to send, captured when start is accepted
//   ps2_clk_in   in  raw ps2_clk line level
//   ps2_data_in  in  raw data line level
//   ps2_clk_oe   out 1 = pull ps2_clk low
//   ps2_data_oe  out 1 = pull data low
//   busy         out high from start acceptance until return to IDLE
//   done         out one-cycle pulse: ack received and bus idle again
//   error        out one-cycle pulse on failure
//   err_code[1:0]out cause of the last error, held until the next start
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned FIRST_TIMEOUT_CYCLES = 750000,
    parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int WDOG_W = $clog2(FIRST_TIMEOUT_CYCLES + 1);
    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [WDOG_W-1:0] FIRST_LOAD = WDOG_W'(FIRST_TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] BIT_LOAD   = WDOG_W'(BIT_TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);
    localparam logic [INH_W-1:0]  INH_LOAD   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0]  INH_ONE    = INH_W'(1);

    ps2_state_t        state;
    logic [9:0]        shift;
    logic [3:0]        bit_cnt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [INH_W-1:0]  inh_cnt;

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;  // only the receiver cares about data edges
    logic wdog_expired;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .fall      (data_fall_unused)
    );

    // Loaded with N, the counter reaches 1 on the N-th cycle without a fall,
    // so error is raised N cycles after the load.
    assign wdog_expired = (wdog_cnt <= WDOG_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            wdog_cnt    <= '0;
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        shift      <= {1'b1, odd_parity(cmd), cmd};
                        busy       <= 1'b1;
                        err_code   <= ERR_NONE;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= INH_LOAD;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == '0) begin
                        ps2_data_oe <= 1'b1;  // start bit, clock still held
                        state       <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt - INH_ONE;
                    end
                end

                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    wdog_cnt   <= FIRST_LOAD;
                    bit_cnt    <= '0;
                    state      <= SEND;
                end

                SEND: begin
                    // A fall beats a simultaneous watchdog expiry.
                    if (clk_fall) begin
                        ps2_data_oe <= ~shift[0];
                        shift       <= {1'b0, shift[9:1]};
                        bit_cnt     <= bit_cnt + 4'd1;
                        wdog_cnt    <= BIT_LOAD;
                        if (bit_cnt == 4'd9) begin
                            state <= ACK;
                        end
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt - WDOG_ONE;
                    end
                end

                ACK: begin
                    if (clk_fall) begin
                        wdog_cnt <= BIT_LOAD;
                        if (!data_sync) begin
                            state <= WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            busy        <= 1'b0;
                            error       <= 1'b1;
                            err_code    <= ERR_NOACK;
                            state       <= IDLE;
                        end
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt - WDOG_ONE;
                    end
                end

                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt - WDOG_ONE;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// PS/2 device on open-drain lines. Expected frames and outcomes are queued
// when a request is issued and compared when the device/DUT produce them.
// Timing parameters are scaled down so the run stays short.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 50;
    localparam int FIRST = 600;
    localparam int BITTO = 200;
    localparam int HP    = 20;   // device clock half period in clk cycles

    localparam int MODE_ACK     = 0;
    localparam int MODE_NOCLK   = 1;
    localparam int MODE_NOACK   = 2;
    localparam int MODE_STALL   = 3;

    typedef struct {
        int         kind;   // 1 = done, 2 = error
        logic [1:0] code;
    } outcome_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cmd;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    // Wired-AND open-drain bus: either side may pull a line low.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .FIRST_TIMEOUT_CYCLES (FIRST),
        .BIT_TIMEOUT_CYCLES   (BITTO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cmd         (cmd),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int rel_cyc;
    int last_fall_cyc;

    logic [10:0] frame_q[$];
    outcome_t    out_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done)          done_cnt++;
        if (error)         err_cnt++;
        if (done && error) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame as the device sees it: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] c);
        logic par;
        par = ($countones(c) % 2) == 0;
        return {1'b1, par, c, 1'b0};
    endfunction

    task automatic pulse_start(input logic [7:0] c);
        @(negedge clk);
        cmd   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmd   = ~c;
        check("busy_on_start", busy, 1'b1);
        check("errcode_cleared", err_code, ERR_NONE);
    endtask

    // Device: waits for the request, then issues n_falls clock pulses,
    // sampling data before fall 1 and at each rising edge.
    task automatic dev_run(input int n_falls, input bit ack, output logic [10:0] seen);
        int t;
        int len;
        seen = '1;
        t = 0;
        while (!ps2_clk_oe && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", ps2_clk_oe, 1'b1);
        if (!ps2_clk_oe) return;
        len = 0;
        while (ps2_clk_oe && len < INH + 100) begin
            len++;
            @(negedge clk);
        end
        rel_cyc = cyc;
        check("inhibit_len", len, INH + 1);
        check("start_bit_oe", ps2_data_oe, 1'b1);
        repeat (HP) @(negedge clk);
        seen[0] = ps2_data_in;
        for (int i = 0; i < n_falls; i++) begin
            if (i == 10 && ack) begin
                dev_data = 1'b0;
                repeat (4) @(negedge clk);
            end
            dev_clk       = 1'b0;
            last_fall_cyc = cyc;
            repeat (HP) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) seen[i+1] = ps2_data_in;
            repeat (HP) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_outcome(output int kind, output int at_cyc, output logic busy_s,
                                output logic clk_oe_s, output logic data_oe_s);
        kind = 0;
        at_cyc = 0;
        busy_s = 1'b1;
        clk_oe_s = 1'b1;
        data_oe_s = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done || error) begin
                kind      = done ? 1 : 2;
                at_cyc    = cyc;
                busy_s    = busy;
                clk_oe_s  = ps2_clk_oe;
                data_oe_s = ps2_data_oe;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic [7:0] c, input int mode, input bit inject);
        outcome_t    exp_o;
        outcome_t    got_o;
        logic [10:0] seen;
        logic [10:0] exp_f;
        int          n_falls;
        int          kind;
        int          at_cyc;
        int          d0;
        int          delta;
        logic        busy_s, clk_oe_s, data_oe_s;

        case (mode)
            MODE_ACK:   begin exp_o.kind = 1; exp_o.code = ERR_NONE;    n_falls = 11; end
            MODE_NOCLK: begin exp_o.kind = 2; exp_o.code = ERR_TIMEOUT; n_falls = 0;  end
            MODE_NOACK: begin exp_o.kind = 2; exp_o.code = ERR_NOACK;   n_falls = 11; end
            default:    begin exp_o.kind = 2; exp_o.code = ERR_TIMEOUT; n_falls = 5;  end
        endcase
        if (mode == MODE_ACK || mode == MODE_NOACK) frame_q.push_back(exp_frame(c));
        out_q.push_back(exp_o);
        d0 = done_cnt;

        pulse_start(c);
        fork
            dev_run(n_falls, mode == MODE_ACK, seen);
            wait_outcome(kind, at_cyc, busy_s, clk_oe_s, data_oe_s);
            if (inject) begin
                repeat (INH + 2 + 100) @(negedge clk);
                cmd   = CMD_RESET;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join

        if (mode == MODE_ACK || mode == MODE_NOACK) begin
            exp_f = frame_q.pop_front();
            check("frame_bits", seen, exp_f);
            check("parity_bit", seen[9], exp_f[9]);
        end
        got_o = out_q.pop_front();
        check("outcome_kind", kind, got_o.kind);
        check("err_code", err_code, got_o.code);
        check("busy_drops", busy_s, 1'b0);
        check("clk_oe_released", clk_oe_s, 1'b0);
        check("data_oe_released", data_oe_s, 1'b0);

        if (mode == MODE_NOCLK) begin
            delta = at_cyc - rel_cyc;
            check("first_timeout_window", (delta >= FIRST - 2) && (delta <= FIRST + 2), 1'b1);
        end
        if (mode == MODE_STALL) begin
            delta = at_cyc - last_fall_cyc;
            check("bit_timeout_window", (delta >= BITTO) && (delta <= BITTO + 5), 1'b1);
        end

        repeat (10) @(negedge clk);
        check("done_count", done_cnt - d0, (mode == MODE_ACK) ? 1 : 0);
        check("err_code_held", err_code, got_o.code);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [10:0] seen;
        int          d0;

        reset = 1'b1;
        start = 1'b0;
        cmd   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_code", err_code, ERR_NONE);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_txn(CMD_SET_LEDS, MODE_ACK,   1'b0);
        run_txn(8'h07,        MODE_ACK,   1'b0);
        run_txn(8'h00,        MODE_ACK,   1'b0);
        run_txn(CMD_ENABLE,   MODE_NOCLK, 1'b0);
        run_txn(8'hA5,        MODE_NOACK, 1'b0);
        run_txn(8'h3C,        MODE_STALL, 1'b0);
        run_txn(8'h12,        MODE_ACK,   1'b1);

        // Reset in the middle of SEND: with cmd 0x00 data is pulled low.
        d0 = done_cnt;
        pulse_start(8'h00);
        dev_run(3, 1'b0, seen);
        check("pre_reset_data_oe", ps2_data_oe, 1'b1);
        check("pre_reset_busy", busy, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 1'b0);
        check("async_rst_data_oe", ps2_data_oe, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", busy, 1'b0);

        check("done_error_overlap", both_cnt, 0);
        check("frame_q_empty", frame_q.size(), 0);
        check("out_q_empty", out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
